// File: rtl/dataword_pkg.sv
// Shared types and lane constants for the FFT sample loader.
package dataword_pkg;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

  localparam logic [3:0] LANE_LEFT_WE  = 4'b1100;
  localparam logic [3:0] LANE_RIGHT_WE = 4'b0011;

endpackage

// File: rtl/fft_loader_addr_map.sv
// Maps a sample index to its BRAM word address and lane byte enables.
// Define FFT_LOADER_BITREV_EN to feed the index through a bit reversal first.
module fft_loader_addr_map
  import dataword_pkg::*;
#(
  parameter int STAGES = 10
) (
  input  logic [STAGES-1:0] i_idx,
  output logic [STAGES-2:0] o_addr,
  output logic [3:0]        o_we
);

  logic [STAGES-1:0] w_k;

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    w_k = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_k[i] = i_idx[STAGES-1-i];
    end
  end
`else
  assign w_k = i_idx;
`endif

  // The index MSB picks the lane so sample n and n+POINTS/2 share a word.
  assign o_addr = w_k[STAGES-2:0];
  assign o_we   = w_k[STAGES-1] ? LANE_RIGHT_WE : LANE_LEFT_WE;

endmodule

// File: rtl/fft_stream_loader.sv
// AXI4-Stream to dual-sample BRAM loader for the FFT core (port A side).
// Optional bit-reversed input ordering via FFT_LOADER_BITREV_EN.
module fft_stream_loader
  import dataword_pkg::*;
#(
  parameter int POINTS  = 1024,
  parameter int STAGES  = 10,
  parameter int WORDLEN = 32,
  localparam int ADDRW  = STAGES - 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [15:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic               bram_en_o,
  output logic [3:0]         bram_we_o,
  output logic [ADDRW-1:0]   bram_addr_o,
  output logic [WORDLEN-1:0] bram_din_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               tlast_err_o
);

  loader_state_t      r_state;
  logic [STAGES-1:0]  r_cnt;
  logic               r_tready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_en;
  logic [3:0]         r_we;
  logic [ADDRW-1:0]   r_addr;
  logic [WORDLEN-1:0] r_din;

  logic               w_hs;
  logic               w_last;
  sample_t            w_sample;
  logic [ADDRW-1:0]   w_map_addr;
  logic [3:0]         w_map_we;

  assign w_hs     = s_axis_tvalid & r_tready;
  assign w_last   = (r_cnt == STAGES'(POINTS - 1));
  assign w_sample = s_axis_tdata;

  fft_loader_addr_map #(
    .STAGES (STAGES)
  ) u_addr_map (
    .i_idx  (r_cnt),
    .o_addr (w_map_addr),
    .o_we   (w_map_we)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tready <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_en     <= 1'b0;
      r_we     <= '0;
      r_addr   <= '0;
      r_din    <= '0;
    end else begin
      r_en   <= w_hs;
      r_we   <= w_hs ? w_map_we : '0;
      r_done <= 1'b0;
      // Both lanes carry the same sample; byte enables pick the half written.
      if (w_hs) begin
        r_addr <= w_map_addr;
        r_din  <= WORDLEN'({w_sample, w_sample});
        r_cnt  <= r_cnt + 1'b1;
        if (s_axis_tlast != w_last) begin
          r_err <= 1'b1;
        end
      end
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state  <= LOAD;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_tready <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (w_hs && w_last) begin
            r_state  <= DONE;
            r_tready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign tlast_err_o   = r_err;
  assign bram_en_o     = r_en;
  assign bram_we_o     = r_we;
  assign bram_addr_o   = r_addr;
  assign bram_din_o    = r_din;

endmodule
